// File: rtl/operand_skew_bank_if.sv
// Host load stream into the operand skew bank: element-at-a-time valid/ready transfer.
interface operand_skew_bank_if #(
  parameter int DW = 8
);
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;

  modport master (output in_valid, output in_data, input  in_ready);
  modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface

// File: rtl/operand_skew_bank.sv
// Stores a W (M x K) and X (K x P) operand pair, then replays them diagonally skewed
// onto N row/column lanes of an output-stationary systolic MAC array.
module operand_skew_bank #(
  parameter  int DW   = 8,
  parameter  int N    = 4,
  localparam int DIMW = $clog2(N + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                cfg_valid,
  input  logic [DIMW-1:0]     rows_w,
  input  logic [DIMW-1:0]     cols_w,
  input  logic [DIMW-1:0]     rows_x,
  input  logic [DIMW-1:0]     cols_x,
  output logic                cfg_err,
  operand_skew_bank_if.slave  in_if,
  output logic [N*DW-1:0]     w_lane,
  output logic [N*DW-1:0]     x_lane,
  output logic [2*N-1:0]      lane_vld,
  output logic [N*N-1:0]      mac_en,
  output logic                mac_clr,
  output logic                done
);

  localparam int AW = (N > 1) ? $clog2(N * N) : 1;
  localparam int SW = $clog2(2 * N);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_LOAD_X,
    S_STREAM,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [DIMW-1:0] r_m, r_k, r_p;
  logic [DIMW-1:0] r_row, r_col;
  logic [SW-1:0]   r_step;
  logic [DW-1:0]   r_wmem [N*N];
  logic [DW-1:0]   r_xmem [N*N];

  logic            w_cfg_ok;
  logic            w_beat;
  logic [DIMW-1:0] w_nrows, w_ncols;
  logic [AW-1:0]   w_addr;
  logic [31:0]     w_mi, w_ki, w_pi, w_si, w_slast;
  logic [N*N-1:0]  w_mask;
  logic [N*DW-1:0] w_wl, w_xl;
  logic [2*N-1:0]  w_vld;

  assign w_cfg_ok = (rows_w != '0) && (rows_w <= DIMW'(N)) &&
                    (cols_w != '0) && (cols_w <= DIMW'(N)) &&
                    (cols_x != '0) && (cols_x <= DIMW'(N)) &&
                    (rows_x == cols_w);

  assign in_if.in_ready = (r_state == S_LOAD_W) || (r_state == S_LOAD_X);
  assign w_beat         = in_if.in_valid && in_if.in_ready;

  assign w_nrows = (r_state == S_LOAD_W) ? r_m : r_k;
  assign w_ncols = (r_state == S_LOAD_W) ? r_k : r_p;
  assign w_addr  = AW'(32'(r_row) * N + 32'(r_col));

  assign w_mi    = 32'(r_m);
  assign w_ki    = 32'(r_k);
  assign w_pi    = 32'(r_p);
  assign w_si    = 32'(r_step);
  assign w_slast = w_ki + N - 2;

  always_comb begin
    w_mask = '0;
    for (int unsigned i = 0; i < N; i++) begin
      for (int unsigned j = 0; j < N; j++) begin
        w_mask[i*N+j] = (i < w_mi) && (j < w_pi);
      end
    end
  end

  // Lane i lags the step counter by i cycles; out-of-range lanes stay zero and invalid.
  always_comb begin
    w_wl  = '0;
    w_xl  = '0;
    w_vld = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if ((i < w_mi) && (w_si >= i) && ((w_si - i) < w_ki)) begin
        w_wl[i*DW +: DW] = r_wmem[AW'(i * N + (w_si - i))];
        w_vld[i]         = 1'b1;
      end
      if ((i < w_pi) && (w_si >= i) && ((w_si - i) < w_ki)) begin
        w_xl[i*DW +: DW] = r_xmem[AW'((w_si - i) * N + i)];
        w_vld[N+i]       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_beat) begin
      if (r_state == S_LOAD_W) r_wmem[w_addr] <= in_if.in_data;
      else                     r_xmem[w_addr] <= in_if.in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_m      <= '0;
      r_k      <= '0;
      r_p      <= '0;
      r_row    <= '0;
      r_col    <= '0;
      r_step   <= '0;
      cfg_err  <= 1'b0;
      w_lane   <= '0;
      x_lane   <= '0;
      lane_vld <= '0;
      mac_en   <= '0;
      mac_clr  <= 1'b0;
      done     <= 1'b0;
    end else if (clear) begin
      r_state  <= S_IDLE;
      r_row    <= '0;
      r_col    <= '0;
      r_step   <= '0;
      w_lane   <= '0;
      x_lane   <= '0;
      lane_vld <= '0;
      mac_en   <= '0;
      mac_clr  <= 1'b0;
      done     <= 1'b0;
    end else begin
      mac_clr  <= 1'b0;
      w_lane   <= '0;
      x_lane   <= '0;
      lane_vld <= '0;
      case (r_state)
        S_IDLE, S_DONE: begin
          mac_en <= '0;
          if (cfg_valid) begin
            if (w_cfg_ok) begin
              r_m     <= rows_w;
              r_k     <= cols_w;
              r_p     <= cols_x;
              r_row   <= '0;
              r_col   <= '0;
              r_step  <= '0;
              cfg_err <= 1'b0;
              done    <= 1'b0;
              r_state <= S_LOAD_W;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        S_LOAD_W, S_LOAD_X: begin
          if (w_beat) begin
            if (r_col == w_ncols - 1'b1) begin
              r_col <= '0;
              if (r_row == w_nrows - 1'b1) begin
                r_row <= '0;
                if (r_state == S_LOAD_W) begin
                  r_state <= S_LOAD_X;
                end else begin
                  r_state <= S_STREAM;
                  r_step  <= '0;
                  mac_clr <= 1'b1;
                  mac_en  <= w_mask;
                end
              end else begin
                r_row <= r_row + 1'b1;
              end
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
        S_STREAM: begin
          w_lane   <= w_wl;
          x_lane   <= w_xl;
          lane_vld <= w_vld;
          mac_en   <= w_mask;
          // mac_en stays high into the first DONE cycle so the last lane values get accumulated.
          if (w_si == w_slast) begin
            r_state <= S_DONE;
            done    <= 1'b1;
          end else begin
            r_step <= r_step + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_skew_bank.sv
// Randomised and directed bench for operand_skew_bank against a matrix-level reference model.
module tb_operand_skew_bank;
  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int DIMW = $clog2(N + 1);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            clear = 1'b0;
  logic            cfg_valid = 1'b0;
  logic [DIMW-1:0] rows_w = '0, cols_w = '0, rows_x = '0, cols_x = '0;
  logic            cfg_err;
  logic [N*DW-1:0] w_lane, x_lane;
  logic [2*N-1:0]  lane_vld;
  logic [N*N-1:0]  mac_en;
  logic            mac_clr, done;

  int n_checks = 0;
  int n_errors = 0;

  operand_skew_bank_if #(.DW(DW)) bus ();

  operand_skew_bank #(.DW(DW), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .cfg_valid(cfg_valid),
    .rows_w(rows_w), .cols_w(cols_w), .rows_x(rows_x), .cols_x(cols_x),
    .cfg_err(cfg_err), .in_if(bus.slave), .w_lane(w_lane), .x_lane(x_lane),
    .lane_vld(lane_vld), .mac_en(mac_en), .mac_clr(mac_clr), .done(done)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 idle, 1 loading, 2 streaming, 3 done; m_t counts cycles since stream entry.
  int m_phase = 0, m_t = 0, m_beats = 0, m_M = 0, m_K = 0, m_P = 0;
  int m_W [N][N];
  int m_X [N][N];
  bit m_err = 0, m_done = 0;

  function automatic bit dims_ok();
    return rows_w >= 1 && rows_w <= N && cols_w >= 1 && cols_w <= N &&
           cols_x >= 1 && cols_x <= N && rows_x == cols_w;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_t = 0; m_beats = 0; m_err = 0; m_done = 0;
    end else if (clear) begin
      m_phase = 0; m_done = 0;
    end else begin
      case (m_phase)
        0, 3: begin
          if (m_phase == 3) m_t++;
          if (cfg_valid) begin
            if (dims_ok()) begin
              m_M = int'(rows_w); m_K = int'(cols_w); m_P = int'(cols_x);
              m_phase = 1; m_beats = 0; m_err = 0; m_done = 0;
            end else begin
              m_err = 1;
            end
          end
        end
        1: if (bus.in_valid) begin
          int b;
          b = m_beats;
          if (b < m_M * m_K) m_W[b / m_K][b % m_K] = int'(bus.in_data);
          else m_X[(b - m_M * m_K) / m_P][(b - m_M * m_K) % m_P] = int'(bus.in_data);
          m_beats++;
          if (m_beats == m_M * m_K + m_K * m_P) begin
            m_phase = 2; m_t = 0;
          end
        end
        2: begin
          m_t++;
          if (m_t == m_K + N - 1) begin
            m_phase = 3; m_done = 1;
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [N*DW-1:0] ew, ex;
    logic [2*N-1:0]  ev;
    logic [N*N-1:0]  em;
    bit              live;
    int              s;
    ew = '0; ex = '0; ev = '0; em = '0;
    live = (m_phase == 2) || (m_phase == 3 && m_t == m_K + N - 1);
    if (live) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          em[i*N+j] = (i < m_M) && (j < m_P);
      if (m_t >= 1) begin
        s = m_t - 1;
        for (int i = 0; i < N; i++) begin
          if (i < m_M && s - i >= 0 && s - i < m_K) begin
            ew[i*DW +: DW] = DW'(m_W[i][s-i]);
            ev[i] = 1'b1;
          end
          if (i < m_P && s - i >= 0 && s - i < m_K) begin
            ex[i*DW +: DW] = DW'(m_X[s-i][i]);
            ev[N+i] = 1'b1;
          end
        end
      end
    end
    chk("in_ready", 64'(bus.in_ready), 64'(m_phase == 1));
    chk("cfg_err", 64'(cfg_err), 64'(m_err));
    chk("done", 64'(done), 64'(m_done));
    chk("mac_clr", 64'(mac_clr), 64'(m_phase == 2 && m_t == 0));
    chk("mac_en", 64'(mac_en), 64'(em));
    chk("w_lane", 64'(w_lane), 64'(ew));
    chk("x_lane", 64'(x_lane), 64'(ex));
    chk("lane_vld", 64'(lane_vld), 64'(ev));
  end

  task automatic do_cfg(input int a, input int b, input int c, input int d);
    cfg_valid = 1'b1;
    rows_w = DIMW'(a); cols_w = DIMW'(b); rows_x = DIMW'(c); cols_x = DIMW'(d);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  // mode 0 back-to-back, 1 alternating, 2 bursts of 4 with 3-cycle gaps, 3 random with stray cfg_valid
  task automatic load(input int vals[$], input int mode);
    int idx = 0;
    int cyc = 0;
    int gap = 0;
    bit v;
    while (idx < vals.size() && cyc < 2000) begin
      case (mode)
        0: v = 1'b1;
        1: v = (cyc % 2 == 0);
        2: v = (gap == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      bus.in_valid = v;
      bus.in_data  = v ? DW'(vals[idx]) : DW'($urandom);
      cfg_valid    = (mode == 3) ? 1'($urandom_range(0, 1)) : 1'b0;
      rows_w = DIMW'($urandom_range(1, N)); cols_w = DIMW'($urandom_range(1, N));
      rows_x = cols_w; cols_x = DIMW'($urandom_range(1, N));
      @(posedge clk); #1;
      if (mode == 2) begin
        if (gap > 0) gap--;
        else if (v && (idx % 4) == 3) gap = 3;
      end
      if (v) idx++;
      cyc++;
    end
    bus.in_valid = 1'b0;
    cfg_valid    = 1'b0;
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int w = 0; w < 200; w++) begin
      @(negedge clk);
      if (m_done) begin ok = 1; break; end
    end
    if (!ok) chk("done_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
  endtask

  int lw0 [8];
  int lw1 [8];
  int lx0 [8];
  int l_done_c;
  logic [15:0] l_en;

  task automatic check_literal();
    bit found = 0;
    for (int w = 0; w < 60; w++) begin
      if (w > 0 || 1'b1) @(negedge clk);
      if (m_phase == 2 && m_t == 0) begin found = 1; break; end
    end
    if (!found) begin
      chk("lit_stream_entry_timeout", 64'd0, 64'd1);
    end else begin
      for (int c = 0; c < 8; c++) begin
        if (c > 0) @(negedge clk);
        chk($sformatf("lit_w_c%0d", c), 64'(w_lane), 64'({DW'(lw1[c]), DW'(lw0[c])}));
        chk($sformatf("lit_x0_c%0d", c), 64'(x_lane[DW-1:0]), 64'(lx0[c]));
        chk($sformatf("lit_clr_c%0d", c), 64'(mac_clr), 64'(c == 0));
        chk($sformatf("lit_en_c%0d", c), 64'(mac_en), (c <= l_done_c) ? 64'(l_en) : 64'd0);
        chk($sformatf("lit_done_c%0d", c), 64'(done), 64'(c >= l_done_c));
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic case1_load(input int mode);
    int q[$];
    for (int v = 1; v <= 12; v++) q.push_back(v);
    do_cfg(2, 3, 3, 2);
    load(q, mode);
  endtask

  initial begin
    int q[$];
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_in_ready", 64'(bus.in_ready), 64'd0);
    chk("reset_outputs", 64'({mac_en, lane_vld, mac_clr, done, cfg_err}), 64'd0);

    do_cfg(2, 3, 2, 2);
    chk("bad_cfg_err", 64'(cfg_err), 64'd1);
    chk("bad_cfg_ready", 64'(bus.in_ready), 64'd0);

    lw0 = '{0, 1, 2, 3, 0, 0, 0, 0};
    lw1 = '{0, 0, 4, 5, 6, 0, 0, 0};
    lx0 = '{0, 7, 9, 11, 0, 0, 0, 0};
    l_done_c = 6;
    l_en = 16'h0033;
    for (int mode = 0; mode < 3; mode++) begin
      case1_load(mode);
      if (mode == 0) chk("good_cfg_err_cleared", 64'(cfg_err), 64'd0);
      check_literal();
      wait_done();
    end

    q.delete();
    for (int v = 1; v <= 5; v++) q.push_back(v);
    do_cfg(2, 3, 3, 2);
    load(q, 0);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    chk("clear_ready", 64'(bus.in_ready), 64'd0);
    chk("clear_outputs", 64'({mac_en, lane_vld, mac_clr, done}), 64'd0);
    case1_load(0);
    check_literal();
    wait_done();

    case1_load(0);
    begin
      bit hit = 0;
      for (int w = 0; w < 60; w++) begin
        @(negedge clk);
        if (m_phase == 2 && m_t == 2) begin hit = 1; break; end
      end
      if (!hit) chk("rst_stream_timeout", 64'd0, 64'd1);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_lanes", {w_lane, x_lane}, 64'd0);
    chk("async_rst_ctrl", 64'({lane_vld, mac_en, mac_clr, done, bus.in_ready, cfg_err}), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      chk("post_rst_done", 64'(done), 64'd0);
      @(posedge clk); #1;
    end

    lw0 = '{0, 5, 0, 0, 0, 0, 0, 0};
    lw1 = '{0, 0, 0, 0, 0, 0, 0, 0};
    lx0 = '{0, 9, 0, 0, 0, 0, 0, 0};
    l_done_c = 4;
    l_en = 16'h0001;
    q.delete();
    q.push_back(5);
    q.push_back(9);
    do_cfg(1, 1, 1, 1);
    load(q, 0);
    check_literal();
    chk("one_x_one_x_upper", 64'(x_lane[N*DW-1:DW]), 64'd0);
    wait_done();

    for (int it = 0; it < 25; it++) begin
      int a, b, c, d, nb;
      for (int att = 0; att < 30 && m_phase != 1; att++) begin
        a = $urandom_range(0, 5);
        b = $urandom_range(0, 5);
        c = $urandom_range(0, 1) ? b : $urandom_range(0, 5);
        d = $urandom_range(0, 5);
        do_cfg(a, b, c, d);
      end
      if (m_phase != 1) do_cfg(2, 2, 2, 2);
      q.delete();
      nb = m_M * m_K + m_K * m_P;
      for (int e = 0; e < nb; e++) q.push_back($urandom_range(0, 255));
      load(q, $urandom_range(0, 3));
      wait_done();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
